// File: rtl/cic_decim_ctrl.sv
// cic_decim_ctrl: sequencing controller for a 5-stage CIC decimator.
// Owns the CIC reset and ratio inputs and takes ratio changes over a
// valid/ready config port, rejecting out-of-range ratios. Every start or
// ratio change flushes the CIC and discards the transient output samples.
// The CIC d_clk/d_out pair is re-timed into a one-cycle out_valid/out_data stream.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_enable              level-sensitive run request
//   i_cfg_valid/o_cfg_ready, i_cfg_ratio[15:0]   ratio config handshake
//   o_cfg_err             one-cycle pulse on a rejected ratio
//   o_cic_rst, o_cic_ratio[15:0]                  drive the CIC
//   i_cic_dclk, i_cic_dout[7:0]                   CIC output strobe and data
//   o_out_valid, o_out_data[7:0]                  re-timed sample stream
//   o_busy                high in FLUSH or SETTLE
//   o_state[1:0]          IDLE=0 FLUSH=1 SETTLE=2 RUN=3
//
// Optional feature macro CIC_DECIM_CTRL_STATS_EN adds the o_sample_cnt[31:0]
// and o_reject_cnt[7:0] statistics outputs.
module cic_decim_ctrl #(
    parameter logic [15:0] DEFAULT_RATIO  = 16'd16,
    parameter logic [15:0] MIN_RATIO      = 16'd2,
    parameter logic [15:0] MAX_RATIO      = 16'd4096,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned SETTLE_SAMPLES = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_cfg_valid,
    output logic               o_cfg_ready,
    input  logic [15:0]        i_cfg_ratio,
    output logic               o_cfg_err,
    output logic               o_cic_rst,
    output logic [15:0]        o_cic_ratio,
    input  logic               i_cic_dclk,
    input  logic signed [7:0]  i_cic_dout,
    output logic               o_out_valid,
    output logic signed [7:0]  o_out_data,
    output logic               o_busy,
`ifdef CIC_DECIM_CTRL_STATS_EN
    output logic [31:0]        o_sample_cnt,
    output logic [7:0]         o_reject_cnt,
`endif
    output logic [1:0]         o_state
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLUSH  = 2'd1,
        S_SETTLE = 2'd2,
        S_RUN    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_dclk_q;
    logic               w_edge;
    logic               w_cfg_ready;
    logic               w_xfer;
    logic               w_in_range;
    logic               w_xfer_ok;
    logic               w_xfer_bad;
    logic               w_valid_next;
    logic               r_cic_rst;
    logic [15:0]        r_cic_ratio;
    logic               r_out_valid;
    logic signed [7:0]  r_out_data;
    logic               r_cfg_err;
    logic               r_busy;

    // Config handshake decode
    assign w_cfg_ready = (r_state == S_IDLE) || (r_state == S_RUN);
    assign w_xfer      = i_cfg_valid & w_cfg_ready;
    assign w_in_range  = (i_cfg_ratio >= MIN_RATIO) && (i_cfg_ratio <= MAX_RATIO);
    assign w_xfer_ok   = w_xfer & w_in_range;
    assign w_xfer_bad  = w_xfer & ~w_in_range;

    // Rising edge of the CIC output strobe; history is held low during FLUSH
    assign w_edge = i_cic_dclk & ~r_dclk_q;

    // Next-state, shared flush/settle counter, and output strobe request
    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_valid_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (i_enable && !w_xfer_ok) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (!i_enable) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else if (r_cnt == CNT_W'(RST_CYCLES - 1)) begin
                    w_next     = S_SETTLE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (!i_enable) begin
                    w_next     = S_IDLE;
                    w_cnt_next = '0;
                end else if (w_edge) begin
                    // The SETTLE_SAMPLES-th strobe is itself discarded
                    if (r_cnt == CNT_W'(SETTLE_SAMPLES - 1)) begin
                        w_next     = S_RUN;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_RUN: begin
                w_cnt_next = '0;
                if (!i_enable) begin
                    w_next = S_IDLE;
                end else begin
                    // A strobe in the ratio-change cycle is still delivered
                    w_valid_next = w_edge;
                    if (w_xfer_ok) begin
                        w_next = S_FLUSH;
                    end
                end
            end
            default: begin
                w_next     = S_IDLE;
                w_cnt_next = '0;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_dclk_q    <= 1'b0;
            r_cic_rst   <= 1'b1;
            r_cic_ratio <= DEFAULT_RATIO;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cfg_err   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_cnt       <= w_cnt_next;
            r_dclk_q    <= (r_state == S_FLUSH) ? 1'b0 : i_cic_dclk;
            r_cic_rst   <= (w_next == S_IDLE) || (w_next == S_FLUSH);
            r_busy      <= (w_next == S_FLUSH) || (w_next == S_SETTLE);
            r_out_valid <= w_valid_next;
            r_cfg_err   <= w_xfer_bad;
            if (w_valid_next) begin
                r_out_data <= i_cic_dout;
            end
            if (w_xfer_ok) begin
                r_cic_ratio <= i_cfg_ratio;
            end
        end
    end

`ifdef CIC_DECIM_CTRL_STATS_EN
    logic [31:0] r_sample_cnt;
    logic [7:0]  r_reject_cnt;

    // Saturating statistics; sample count restarts with every flush
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sample_cnt <= '0;
            r_reject_cnt <= '0;
        end else begin
            if ((w_next == S_FLUSH) && (r_state != S_FLUSH)) begin
                r_sample_cnt <= '0;
            end else if (r_out_valid && (r_sample_cnt != 32'hFFFF_FFFF)) begin
                r_sample_cnt <= r_sample_cnt + 32'd1;
            end
            if (w_xfer_bad && (r_reject_cnt != 8'hFF)) begin
                r_reject_cnt <= r_reject_cnt + 8'd1;
            end
        end
    end

    assign o_sample_cnt = r_sample_cnt;
    assign o_reject_cnt = r_reject_cnt;
`endif

    assign o_cfg_ready = w_cfg_ready;
    assign o_cfg_err   = r_cfg_err;
    assign o_cic_rst   = r_cic_rst;
    assign o_cic_ratio = r_cic_ratio;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_busy      = r_busy;
    assign o_state     = r_state;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb_cic_decim_ctrl: directed bench for cic_decim_ctrl. A small behavioural
// CIC stand-in emits one d_clk strobe every "ratio" clocks while out of reset,
// with d_out equal to the running strobe number since its last reset.
module tb_cic_decim_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [15:0]        cfg_ratio;
    logic               cfg_err;
    logic               cic_rst;
    logic [15:0]        cic_ratio;
    logic               cic_dclk;
    logic signed [7:0]  cic_dout;
    logic               out_valid;
    logic signed [7:0]  out_data;
    logic               busy;
    logic [1:0]         state;
`ifdef CIC_DECIM_CTRL_STATS_EN
    logic [31:0]        sample_cnt;
    logic [7:0]         reject_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cic_decim_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_enable    (enable),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_ratio (cfg_ratio),
        .o_cfg_err   (cfg_err),
        .o_cic_rst   (cic_rst),
        .o_cic_ratio (cic_ratio),
        .i_cic_dclk  (cic_dclk),
        .i_cic_dout  (cic_dout),
        .o_out_valid (out_valid),
        .o_out_data  (out_data),
        .o_busy      (busy),
`ifdef CIC_DECIM_CTRL_STATS_EN
        .o_sample_cnt(sample_cnt),
        .o_reject_cnt(reject_cnt),
`endif
        .o_state     (state)
    );

    // Behavioural CIC output: strobe every cic_ratio clocks, data = strobe number
    logic [15:0] div;
    logic [7:0]  n;
    always @(posedge clk) begin
        if (cic_rst) begin
            div      <= 16'd0;
            n        <= 8'd0;
            cic_dclk <= 1'b0;
            cic_dout <= 8'sd0;
        end else if (div == cic_ratio - 16'd1) begin
            div      <= 16'd0;
            n        <= n + 8'd1;
            cic_dclk <= 1'b1;
            cic_dout <= $signed(n + 8'd1);
        end else begin
            div      <= div + 16'd1;
            cic_dclk <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance until out_valid is seen; n = clocks advanced
    task automatic wait_valid(input string tag, input int budget, output int cyc);
        cyc = 0;
        forever begin
            tick();
            cyc++;
            if (out_valid === 1'b1) return;
            if (cyc >= budget) begin
                checks++;
                errors++;
                $error("FAIL %s timeout observed=no out_valid expected=out_valid within %0d", tag, budget);
                return;
            end
        end
    endtask

    task automatic wait_state(input string tag, input logic [1:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (state === s) return;
            tick();
        end
        checks++;
        errors++;
        $error("FAIL %s timeout observed=%0d expected=%0d", tag, state, s);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"},     32'(state),     32'd0);
        check({tag, "_cic_rst"},   32'(cic_rst),   32'd1);
        check({tag, "_cic_ratio"}, 32'(cic_ratio), 32'd16);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_cfg_err"},   32'(cfg_err),   32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
`ifdef CIC_DECIM_CTRL_STATS_EN
        check({tag, "_sample_cnt"}, sample_cnt,       32'd0);
        check({tag, "_reject_cnt"}, 32'(reject_cnt),  32'd0);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int fl;
        int d0;
        int cnt;

        rst       = 1'b1;
        enable    = 1'b1;
        cfg_valid = 1'b0;
        cfg_ratio = 16'd0;

        // Reset held with enable high
        tick();
        tick();
        check_reset_values("reset");
        check("reset_cfg_ready", 32'(cfg_ready), 32'd1);

        // Startup: 4 flush cycles, 6 discarded strobes, 7th delivered
        rst = 1'b0;
        wait_state("enter_flush", 2'd1, 5);
        fl = 0;
        while (state === 2'd1 && fl < 50) begin
            check("flush_cic_rst", 32'(cic_rst), 32'd1);
            check("flush_busy", 32'(busy), 32'd1);
            fl++;
            tick();
        end
        check("flush_len", 32'(fl), 32'd4);
        check("settle_state", 32'(state), 32'd2);
        check("settle_cic_rst", 32'(cic_rst), 32'd0);
        check("settle_cfg_ready", 32'(cfg_ready), 32'd0);
        wait_valid("first_valid", 400, cyc);
        check("first_valid_state", 32'(state), 32'd3);
        check("first_valid_data", 32'(out_data), 32'd7);
        check("first_valid_busy", 32'(busy), 32'd0);
        tick();
        check("valid_one_cycle", 32'(out_valid), 32'd0);
        wait_valid("second_valid", 40, cyc);
        check("period_16", 32'(cyc + 1), 32'd16);
        check("second_valid_data", 32'(out_data), 32'd8);

        // Ratio change to 8 in RUN
        cfg_valid = 1'b1;
        cfg_ratio = 16'd8;
        tick();
        cfg_valid = 1'b0;
        check("chg_state", 32'(state), 32'd1);
        check("chg_cic_rst", 32'(cic_rst), 32'd1);
        check("chg_cic_ratio", 32'(cic_ratio), 32'd8);
        check("chg_cfg_err", 32'(cfg_err), 32'd0);
`ifdef CIC_DECIM_CTRL_STATS_EN
        check("chg_sample_cnt", sample_cnt, 32'd0);
`endif
        wait_valid("chg_first_valid", 200, cyc);
        check("chg_first_data", 32'(out_data), 32'd7);
        wait_valid("chg_second_valid", 40, cyc);
        check("period_8", 32'(cyc), 32'd8);

        // Out-of-range ratios 1 and 5000 rejected without disturbing cadence
        d0 = int'(out_data);
        cfg_valid = 1'b1;
        cfg_ratio = 16'd1;
        tick();
        cfg_valid = 1'b0;
        check("rej1_cfg_err", 32'(cfg_err), 32'd1);
        check("rej1_cic_ratio", 32'(cic_ratio), 32'd8);
        check("rej1_state", 32'(state), 32'd3);
        tick();
        check("rej1_err_pulse", 32'(cfg_err), 32'd0);
        cfg_valid = 1'b1;
        cfg_ratio = 16'd5000;
        tick();
        cfg_valid = 1'b0;
        check("rej2_cfg_err", 32'(cfg_err), 32'd1);
        check("rej2_cic_ratio", 32'(cic_ratio), 32'd8);
        check("rej2_state", 32'(state), 32'd3);
        tick();
        check("rej2_err_pulse", 32'(cfg_err), 32'd0);
        wait_valid("rej_next_valid", 40, cyc);
        check("rej_period", 32'(cyc + 4), 32'd8);
        check("rej_data", 32'(int'(out_data)), 32'(d0 + 1));
`ifdef CIC_DECIM_CTRL_STATS_EN
        check("rej_reject_cnt", 32'(reject_cnt), 32'd2);
`endif

        // enable dropped in the same cycle as a ratio-32 transfer
        wait_valid("pre_drop_sync", 40, cyc);
        enable    = 1'b0;
        cfg_valid = 1'b1;
        cfg_ratio = 16'd32;
        tick();
        cfg_valid = 1'b0;
        check("drop_state", 32'(state), 32'd0);
        check("drop_cic_ratio", 32'(cic_ratio), 32'd32);
        check("drop_cic_rst", 32'(cic_rst), 32'd1);
        check("drop_out_valid", 32'(out_valid), 32'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid === 1'b1) cnt++;
        end
        check("drop_no_valid", 32'(cnt), 32'd0);
        enable = 1'b1;
        tick();
        check("reen_state", 32'(state), 32'd1);
        check("reen_cic_ratio", 32'(cic_ratio), 32'd32);
        wait_valid("reen_first_valid", 400, cyc);
        check("reen_first_data", 32'(out_data), 32'd7);
        wait_valid("reen_second_valid", 80, cyc);
        check("period_32", 32'(cyc), 32'd32);

        // Reset pulsed in the middle of SETTLE
        enable = 1'b0;
        tick();
        enable = 1'b1;
        wait_state("enter_settle", 2'd2, 20);
        tick();
        tick();
        check("mid_settle_state", 32'(state), 32'd2);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        rst = 1'b0;
        tick();
        check("restart_state", 32'(state), 32'd1);
        wait_valid("restart_first_valid", 400, cyc);
        check("restart_first_data", 32'(out_data), 32'd7);
        wait_valid("restart_second_valid", 40, cyc);
        check("restart_period_16", 32'(cyc), 32'd16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
